// File: rtl/pif_ram_arbiter_if.sv
// PIF RAM arbiter bus bundle: N64 port, 6502 port and shared RAM port.
// slave is the arbiter side, master is the requester/RAM side.
interface pif_ram_arbiter_if;
  logic        n64_req;
  logic [8:0]  n64_addr;
  logic        n64_we;
  logic [31:0] n64_wdata;
  logic        n64_valid;
  logic [31:0] n64_rdata;
  logic        cpu_req;
  logic [10:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic        cpu_valid;
  logic [7:0]  cpu_rdata;
  logic [8:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        busy;

  modport slave (
    input  n64_req, n64_addr, n64_we, n64_wdata,
    input  cpu_req, cpu_addr, cpu_we, cpu_wdata,
    input  ram_rdata,
    output n64_valid, n64_rdata, cpu_valid, cpu_rdata,
    output ram_addr, ram_we, ram_be, ram_wdata, busy
  );

  modport master (
    output n64_req, n64_addr, n64_we, n64_wdata,
    output cpu_req, cpu_addr, cpu_we, cpu_wdata,
    output ram_rdata,
    input  n64_valid, n64_rdata, cpu_valid, cpu_rdata,
    input  ram_addr, ram_we, ram_be, ram_wdata, busy
  );
endinterface

// File: rtl/pif_ram_arbiter.sv
// Shares one 512x32 RAM between the N64 word port and the 6502 byte port,
// with N64 priority bounded by a CPU starvation limit.
module pif_ram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             reset_l,
  pif_ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] streak;
  logic       owner_cpu;
  logic       lat_we;
  logic [1:0] lane;
  logic       at_limit;
  logic       cpu_win;

  assign at_limit = (streak == 4'(STARVE_LIMIT));
  assign bus.busy = (state != IDLE);

  always_comb begin
    cpu_win = bus.cpu_req & (~bus.n64_req | at_limit);
  end

  // reset_l is active-high despite its name
  always_ff @(posedge clk or posedge reset_l) begin
    if (reset_l) begin
      state         <= IDLE;
      streak        <= '0;
      owner_cpu     <= 1'b0;
      lat_we        <= 1'b0;
      lane          <= '0;
      bus.ram_addr  <= '0;
      bus.ram_we    <= 1'b0;
      bus.ram_be    <= '0;
      bus.ram_wdata <= '0;
      bus.n64_valid <= 1'b0;
      bus.cpu_valid <= 1'b0;
      bus.n64_rdata <= '0;
      bus.cpu_rdata <= '0;
    end else begin
      bus.ram_we    <= 1'b0;
      bus.ram_be    <= '0;
      bus.n64_valid <= 1'b0;
      bus.cpu_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.n64_req | bus.cpu_req) begin
            state     <= ACCESS;
            owner_cpu <= cpu_win;
            lane      <= bus.cpu_addr[1:0];
            if (cpu_win) begin
              lat_we        <= bus.cpu_we;
              bus.ram_addr  <= bus.cpu_addr[10:2];
              bus.ram_wdata <= {4{bus.cpu_wdata}};
              bus.ram_we    <= bus.cpu_we;
              bus.ram_be    <= bus.cpu_we ?
                               (4'b1000 >> bus.cpu_addr[1:0]) :
                               4'b0000;
              streak        <= '0;
            end else begin
              lat_we        <= bus.n64_we;
              bus.ram_addr  <= bus.n64_addr;
              bus.ram_wdata <= bus.n64_wdata;
              bus.ram_we    <= bus.n64_we;
              bus.ram_be    <= {4{bus.n64_we}};
              if (!bus.cpu_req)
                streak <= '0;
              else if (!at_limit)
                streak <= streak + 4'd1;
            end
          end
        end
        ACCESS: state <= WAIT;
        WAIT: begin
          state <= DONE;
          // big-endian lanes: lane 0 is bits 31:24
          if (!lat_we) begin
            if (owner_cpu)
              bus.cpu_rdata <= 8'(bus.ram_rdata >> {~lane, 3'b000});
            else
              bus.n64_rdata <= bus.ram_rdata;
          end
          if (owner_cpu)
            bus.cpu_valid <= 1'b1;
          else
            bus.n64_valid <= 1'b1;
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pif_ram_arbiter.sv
// Scoreboard bench for pif_ram_arbiter: directed vectors push expected
// completions and RAM writes, independent monitors pop and compare.
module tb_pif_ram_arbiter;

  logic clk;
  logic reset_l;
  int   cyc;
  int   pass_cnt;
  int   total_cnt;

  pif_ram_arbiter_if bus ();

  pif_ram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  typedef struct {
    bit          cpu;
    logic [10:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic [8:0]  ra;
    logic [3:0]  be;
    logic [31:0] rw;
  } vec_t;

  typedef struct {
    bit          cpu;
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic [8:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
  } ram_t;

  vec_t vq[$];
  exp_t sb[$];
  ram_t rq[$];

  logic [31:0] mem [512];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (bus.ram_we) begin
      if (bus.ram_be[3]) mem[bus.ram_addr][31:24] <= bus.ram_wdata[31:24];
      if (bus.ram_be[2]) mem[bus.ram_addr][23:16] <= bus.ram_wdata[23:16];
      if (bus.ram_be[1]) mem[bus.ram_addr][15:8]  <= bus.ram_wdata[15:8];
      if (bus.ram_be[0]) mem[bus.ram_addr][7:0]   <= bus.ram_wdata[7:0];
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  name, act, exp, cyc);
  endtask

  // completion monitor
  always @(negedge clk) begin
    if (!reset_l && (bus.n64_valid || bus.cpu_valid)) begin
      exp_t e;
      chk("valid_exclusive", 64'(bus.n64_valid & bus.cpu_valid), 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("valid_source", 64'(bus.cpu_valid), 64'(e.cpu));
        chk("rdata", e.cpu ? 64'(bus.cpu_rdata) : 64'(bus.n64_rdata),
            64'(e.data));
        if (e.due >= 0) chk("latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  // RAM write monitor; a two-cycle ram_we finds an empty queue
  always @(negedge clk) begin
    if (!reset_l && bus.ram_we) begin
      ram_t r;
      if (rq.size() == 0) begin
        chk("unexpected_ram_we", 64'd1, 64'd0);
      end else begin
        r = rq.pop_front();
        chk("ram_addr", 64'(bus.ram_addr), 64'(r.a));
        chk("ram_be", 64'(bus.ram_be), 64'(r.be));
        chk("ram_wdata", 64'(bus.ram_wdata), 64'(r.d));
      end
    end
  end

  task automatic run(input vec_t v);
    bit got;
    got = 1'b0;
    @(negedge clk);
    sb.push_back('{v.cpu, v.exp, cyc + 3});
    if (v.we) rq.push_back('{v.ra, v.be, v.rw});
    if (v.cpu) begin
      bus.cpu_addr  = v.addr;
      bus.cpu_we    = v.we;
      bus.cpu_wdata = v.wdata[7:0];
      bus.cpu_req   = 1'b1;
    end else begin
      bus.n64_addr  = v.addr[8:0];
      bus.n64_we    = v.we;
      bus.n64_wdata = v.wdata;
      bus.n64_req   = 1'b1;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = v.cpu ? bus.cpu_valid : bus.n64_valid;
    end
    if (!got) chk("op_timeout", 64'd1, 64'd0);
    bus.cpu_req = 1'b0;
    bus.n64_req = 1'b0;
    bus.cpu_we  = 1'b0;
    bus.n64_we  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int seen;
    pass_cnt  = 0;
    total_cnt = 0;
    cyc       = 0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[5] = 32'h11223344;
    bus.n64_req = 0; bus.n64_addr = 0; bus.n64_we = 0; bus.n64_wdata = 0;
    bus.cpu_req = 0; bus.cpu_addr = 0; bus.cpu_we = 0; bus.cpu_wdata = 0;
    reset_l = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_valids", 64'({bus.n64_valid, bus.cpu_valid}), 64'd0);
    chk("reset_ram", {bus.ram_we, bus.ram_be, bus.ram_addr, bus.ram_wdata},
        64'd0);
    chk("reset_rdata", {bus.n64_rdata, bus.cpu_rdata}, 64'd0);
    reset_l = 1'b0;

    //           cpu  addr     we  wdata         exp rdata     ra      be       ram wdata
    vq.push_back('{0, 11'h005, 0, 32'h0,        32'h11223344, 9'h0,   4'h0, 32'h0});
    vq.push_back('{1, 11'h016, 1, 32'hA5,       32'h0,        9'h005, 4'h2, 32'hA5A5A5A5});
    vq.push_back('{0, 11'h005, 0, 32'h0,        32'h1122A544, 9'h0,   4'h0, 32'h0});
    vq.push_back('{0, 11'h005, 1, 32'h11223344, 32'h1122A544, 9'h005, 4'hF, 32'h11223344});
    vq.push_back('{1, 11'h014, 0, 32'h0,        32'h11,       9'h0,   4'h0, 32'h0});
    vq.push_back('{1, 11'h015, 0, 32'h0,        32'h22,       9'h0,   4'h0, 32'h0});
    vq.push_back('{1, 11'h016, 0, 32'h0,        32'h33,       9'h0,   4'h0, 32'h0});
    vq.push_back('{1, 11'h017, 0, 32'h0,        32'h44,       9'h0,   4'h0, 32'h0});
    vq.push_back('{0, 11'h1FF, 1, 32'hDEADBEEF, 32'h1122A544, 9'h1FF, 4'hF, 32'hDEADBEEF});
    vq.push_back('{0, 11'h1FF, 0, 32'h0,        32'hDEADBEEF, 9'h0,   4'h0, 32'h0});
    vq.push_back('{1, 11'h7FC, 1, 32'h5A,       32'h44,       9'h1FF, 4'h8, 32'h5A5A5A5A});
    vq.push_back('{0, 11'h1FF, 0, 32'h0,        32'h5AADBEEF, 9'h0,   4'h0, 32'h0});
    vq.push_back('{1, 11'h7FF, 0, 32'h0,        32'hEF,       9'h0,   4'h0, 32'h0});
    foreach (vq[i]) run(vq[i]);

    // simultaneous requests: N64 first, CPU one grant slot later
    @(negedge clk);
    sb.push_back('{0, 32'h5AADBEEF, cyc + 3});
    sb.push_back('{1, 32'h00000011, cyc + 7});
    bus.n64_addr = 9'h1FF;
    bus.cpu_addr = 11'h014;
    bus.n64_req  = 1'b1;
    bus.cpu_req  = 1'b1;
    seen = 0;
    for (int i = 0; i < 30 && bus.cpu_req; i++) begin
      @(negedge clk);
      if (bus.n64_valid) bus.n64_req = 1'b0;
      if (bus.cpu_valid) bus.cpu_req = 1'b0;
    end
    if (bus.cpu_req || bus.n64_req) chk("simul_timeout", 64'd1, 64'd0);
    bus.cpu_req = 1'b0;
    bus.n64_req = 1'b0;

    // starvation: both held, order N,N,N,N,C repeated, grants 4 apart
    @(negedge clk);
    for (int i = 0; i < 10; i++)
      sb.push_back('{(i % 5) == 4,
                     ((i % 5) == 4) ? 32'h44 : 32'h11223344,
                     cyc + 3 + 4 * i});
    bus.n64_addr = 9'h005;
    bus.cpu_addr = 11'h017;
    bus.n64_req  = 1'b1;
    bus.cpu_req  = 1'b1;
    seen = 0;
    for (int i = 0; i < 80 && seen < 10; i++) begin
      @(negedge clk);
      if (bus.n64_valid || bus.cpu_valid) seen++;
    end
    bus.n64_req = 1'b0;
    bus.cpu_req = 1'b0;
    chk("starve_count", 64'(seen), 64'd10);

    // reset in WAIT of a CPU write, request held across reset
    @(negedge clk);
    rq.push_back('{9'h000, 4'h8, 32'h77777777});
    bus.cpu_addr  = 11'h000;
    bus.cpu_wdata = 8'h77;
    bus.cpu_we    = 1'b1;
    bus.cpu_req   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset_l = 1'b1;
    #1;
    chk("abort_outputs",
        {bus.busy, bus.n64_valid, bus.cpu_valid, bus.ram_we, bus.ram_be,
         bus.ram_addr, bus.ram_wdata}, 64'd0);
    chk("abort_rdata", {bus.n64_rdata, bus.cpu_rdata}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rq.push_back('{9'h000, 4'h8, 32'h77777777});
    sb.push_back('{1, 32'h0, cyc + 3});
    reset_l = 1'b0;
    @(posedge clk);
    #1;
    chk("regrant_busy", 64'(bus.busy), 64'd1);
    chk("regrant_ram_we", 64'(bus.ram_we), 64'd1);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.cpu_valid) seen = 1;
    end
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    chk("regrant_done", 64'(seen), 64'd1);

    repeat (6) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);
    chk("mem0_written", 64'(mem[0]), 64'h77000000);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pif_ram_arbiter.md
PIF_RAM_ARBITER -- requirements
Module: pif_ram_arbiter

Interface
REQ-001 SHALL have one clock and a reset that is asynchronous and active-high.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning max consecutive N64 grants while the CPU is waiting (1..15).
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port reset_l, input, 1 bit: asynchronous reset, active-high despite the name.
REQ-005 SHALL have port n64_req, input, 1 bit: N64-side access request, held until n64_valid.
REQ-006 SHALL have port n64_addr, input, 9 bits: word address.
REQ-007 SHALL have ports n64_we (input, 1 bit) and n64_wdata (input, 32 bits): write enable and write word.
REQ-008 SHALL have ports n64_valid (output, 1 bit) and n64_rdata (output, 32 bits): completion pulse and read word.
REQ-009 SHALL have port cpu_req, input, 1 bit: 6502-side access request, held until cpu_valid.
REQ-010 SHALL have port cpu_addr, input, 11 bits: byte address.
REQ-011 SHALL have ports cpu_we (input, 1 bit) and cpu_wdata (input, 8 bits): write enable and write byte.
REQ-012 SHALL have ports cpu_valid (output, 1 bit) and cpu_rdata (output, 8 bits): completion pulse and read byte.
REQ-013 SHALL have RAM-side ports: ram_addr (output, 9 bits), ram_we (output, 1 bit), ram_be (output, 4 bits), ram_wdata (output, 32 bits), ram_rdata (input, 32 bits). The RAM has 1-cycle read latency.
REQ-014 SHALL have port busy, output, 1 bit: high when state is not IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> WAIT -> DONE -> IDLE; every transition is unconditional except leaving IDLE.
REQ-016 IDLE: if either req is high at the clock edge, SHALL latch the winner's address, we and data, go to ACCESS; otherwise stay in IDLE.
REQ-017 Arbitration: N64 wins ties unless streak == STARVE_LIMIT and cpu_req is high, in which case the CPU wins.
REQ-018 Streak counter (4 bits): +1 on an N64 grant while cpu_req is high; cleared on a CPU grant or on an N64 grant with cpu_req low; saturates at STARVE_LIMIT.
REQ-019 ACCESS: SHALL drive ram_addr, ram_wdata and ram_be from the latched request; ram_we = latched we for exactly this one cycle.
REQ-020 N64 access: ram_addr = n64_addr, ram_wdata = n64_wdata, ram_be = 4'b1111 on write.
REQ-021 CPU access: ram_addr = cpu_addr[10:2]; lane = cpu_addr[1:1:0]... big-endian lanes: lane 0 = bits 31:24, lane 3 = bits 7:0. Write: cpu_wdata replicated on all four bytes, ram_be one-hot on the lane (lane 0 -> 4'b1000).
REQ-022 Reads SHALL drive ram_be = 4'b0000; outside ACCESS, ram_we = 0 and ram_be = 0.
REQ-023 WAIT: on a read, SHALL register ram_rdata into the owner's rdata register (CPU: the selected lane byte); on a write, rdata registers hold their prior values.
REQ-024 DONE: SHALL pulse the owner's valid for exactly one cycle; the other valid stays 0.
REQ-025 Latency: request sampled at edge k -> valid high in cycle k+3; minimum spacing between grants is 4 cycles.
REQ-026 A req still high in the cycle after DONE SHALL be treated as a new request.
REQ-027 n64_valid and cpu_valid SHALL never be high in the same cycle.
REQ-028 Changes on req, addr or data inputs while not in IDLE SHALL be ignored (latched values are used).

Reset
REQ-029 Asserting reset_l SHALL immediately force: FSM to IDLE, streak = 0, ram_we = 0, ram_be = 0, ram_addr = 0, ram_wdata = 0, n64_valid = 0, cpu_valid = 0, n64_rdata = 0, cpu_rdata = 0, busy = 0.
REQ-030 Reset during ACCESS, WAIT or DONE SHALL abort the access with no valid pulse; after release, any held req is re-arbitrated from IDLE.

Verification
REQ-031 N64 read: RAM word 0x05 = 0x11223344, n64_req with addr 0x05 at edge 0 -> ram_addr = 0x05 in ACCESS, n64_valid in cycle 3, n64_rdata = 0x11223344.
REQ-032 CPU byte write: cpu_addr = 0x016, wdata = 0xA5 -> ram_addr = 0x005, ram_be = 4'b0010, ram_wdata = 0xA5A5A5A5, ram_we high for 1 cycle, cpu_valid in cycle 3.
REQ-033 CPU byte read lanes: word 0x11223344 at 0x005, reads of 0x014..0x017 -> cpu_rdata = 0x11, 0x22, 0x33, 0x44.
REQ-034 Starvation: both reqs held continuously, STARVE_LIMIT = 4 -> grant order N,N,N,N,C,N,N,N,N,C; cpu_valid never delayed more than 5 accesses.
REQ-035 Simultaneous first request, streak 0 -> N64 wins; the CPU is granted in the cycle after N64's DONE.
REQ-036 Reset asserted in WAIT of a write -> no valid pulse, all outputs 0 at once; held req -> new ACCESS 1 cycle after reset release.
